// File: rtl/lc3_datapath_param_pkg.sv
// Shared encodings, CC reset constant and sign-extension helper for the LC-3 datapath.
// sext() works up to 64 bits; callers truncate the result to WIDTH.
package datapath_pkg;

  localparam logic [2:0] CC_RESET   = 3'b010;
  localparam int         SEXT_MAX_W = 64;

  typedef enum logic [1:0] {
    PCMUX_INC   = 2'b00,
    PCMUX_BUS   = 2'b01,
    PCMUX_ADDER = 2'b10,
    PCMUX_HOLD  = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2mux_e;

  typedef enum logic [1:0] {
    DRMUX_IR    = 2'b00,
    DRMUX_R7    = 2'b01,
    DRMUX_R6    = 2'b10,
    DRMUX_IR_ALT = 2'b11
  } drmux_e;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_e;

  // Sign-extend val[msb:0]: park the field at the top, then arithmetic-shift it back down.
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [15:0] val, input int unsigned msb);
    logic signed [SEXT_MAX_W-1:0] tmp;
    tmp = signed'({val, 48'b0} << (15 - msb));
    return $unsigned(tmp >>> (63 - msb));
  endfunction

endpackage

// File: rtl/lc3_datapath_param_if.sv
// Control/status bundle between the ISDU (master) and the datapath (slave).
interface lc3_datapath_param_if #(
  parameter int WIDTH = 16,
  parameter int LED_W = 12
);
  // No valid/ready handshake: every control is level-sampled on each rising Clk edge.
  logic             GatePC, GateMDR, GateALU, GateMARMUX;
  logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic [1:0]       PCMUX, DRMUX, ADDR2MUX, ALUK;
  logic             SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [WIDTH-1:0] MDR_In;
  logic [WIDTH-1:0] MAR, MDR, IR, PC;
  logic             BEN;
  logic [LED_W-1:0] LED;
  logic             bus_err;
  logic [WIDTH-1:0] dbg_bus;
  logic [2:0]       dbg_cc;

  modport master (
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output PCMUX, DRMUX, ADDR2MUX, ALUK, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, MDR_In,
    input  MAR, MDR, IR, PC, BEN, LED, bus_err, dbg_bus, dbg_cc
  );

  modport slave (
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  PCMUX, DRMUX, ADDR2MUX, ALUK, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, MDR_In,
    output MAR, MDR, IR, PC, BEN, LED, bus_err, dbg_bus, dbg_cc
  );
endinterface

// File: rtl/lc3_datapath_param_reg_file_8.sv
// 8 x WIDTH register file: two combinational read ports, one synchronous write port.
module reg_file_8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd0_idx,
  output logic [WIDTH-1:0] rd0_data,
  input  logic [2:0]       rd1_idx,
  output logic [WIDTH-1:0] rd1_data
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd0_data = regs_q[rd0_idx];
  assign rd1_data = regs_q[rd1_idx];

endmodule

// File: rtl/lc3_datapath_param.sv
// Parametrised LC-3 datapath around a single prioritised WIDTH-bit bus.
// Optional sticky contention flag enabled by defining DATAPATH_BUS_CHECK_EN.
module lc3_datapath_param
  import datapath_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               LED_W    = 12
) (
  input logic                 Clk,
  input logic                 Reset,
  lc3_datapath_param_if.slave dp
);

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [2:0]       cc_q, cc_d;
  logic             ben_q, ben_d;
  logic [LED_W-1:0] led_q, led_d;

  logic [15:0]      ir16;
  logic [2:0]       sr1_idx, dr_idx;
  logic [WIDTH-1:0] sr1_data, sr2_data;
  logic [WIDTH-1:0] addr1, addr2, adder, alu_b, alu_out, bus;

  assign ir16 = ir_q[15:0];

  reg_file_8 #(.WIDTH(WIDTH)) u_regs (
    .clk      (Clk),
    .rst      (Reset),
    .we       (dp.LD_REG),
    .wr_idx   (dr_idx),
    .wr_data  (bus),
    .rd0_idx  (sr1_idx),
    .rd0_data (sr1_data),
    .rd1_idx  (ir16[2:0]),
    .rd1_data (sr2_data)
  );

  always_comb begin
    sr1_idx = dp.SR1MUX ? ir16[8:6] : ir16[11:9];
    case (drmux_e'(dp.DRMUX))
      DRMUX_R7: dr_idx = 3'd7;
      DRMUX_R6: dr_idx = 3'd6;
      default:  dr_idx = ir16[11:9];
    endcase

    addr1 = dp.ADDR1MUX ? sr1_data : pc_q;
    case (addr2mux_e'(dp.ADDR2MUX))
      ADDR2_OFF6:  addr2 = WIDTH'(sext(ir16, 5));
      ADDR2_OFF9:  addr2 = WIDTH'(sext(ir16, 8));
      ADDR2_OFF11: addr2 = WIDTH'(sext(ir16, 10));
      default:     addr2 = '0;
    endcase
    adder = addr1 + addr2;

    alu_b = dp.SR2MUX ? WIDTH'(sext(ir16, 4)) : sr2_data;
    case (aluk_e'(dp.ALUK))
      ALUK_ADD: alu_out = sr1_data + alu_b;
      ALUK_AND: alu_out = sr1_data & alu_b;
      ALUK_NOT: alu_out = ~sr1_data;
      default:  alu_out = sr1_data;
    endcase

    // Fixed priority keeps the bus deterministic even when the ISDU misbehaves.
    if (dp.GatePC)          bus = pc_q;
    else if (dp.GateMDR)    bus = mdr_q;
    else if (dp.GateALU)    bus = alu_out;
    else if (dp.GateMARMUX) bus = adder;
    else                    bus = '0;
  end

  always_comb begin
    pc_d = pc_q;
    if (dp.LD_PC) begin
      case (pcmux_e'(dp.PCMUX))
        PCMUX_INC:   pc_d = pc_q + WIDTH'(1);
        PCMUX_BUS:   pc_d = bus;
        PCMUX_ADDER: pc_d = adder;
        default:     pc_d = pc_q;
      endcase
    end

    mar_d = dp.LD_MAR ? bus : mar_q;
    mdr_d = dp.LD_MDR ? (dp.MIO_EN ? dp.MDR_In : bus) : mdr_q;
    ir_d  = dp.LD_IR ? bus : ir_q;
    led_d = dp.LD_LED ? ir_q[LED_W-1:0] : led_q;

    cc_d = cc_q;
    if (dp.LD_CC) begin
      if (bus[WIDTH-1])    cc_d = 3'b100;
      else if (bus == '0)  cc_d = 3'b010;
      else                 cc_d = 3'b001;
    end

    // Uses cc_q, so a simultaneous LD_CC does not affect this cycle's branch decision.
    ben_d = ben_q;
    if (dp.LD_BEN) ben_d = (ir16[11] & cc_q[2]) | (ir16[10] & cc_q[1]) | (ir16[9] & cc_q[0]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      cc_q  <= CC_RESET;
      ben_q <= 1'b0;
      led_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      cc_q  <= cc_d;
      ben_q <= ben_d;
      led_q <= led_d;
    end
  end

`ifdef DATAPATH_BUS_CHECK_EN
  logic       bus_err_q, bus_err_d;
  logic [2:0] gate_cnt;

  always_comb begin
    gate_cnt  = {2'b0, dp.GatePC} + {2'b0, dp.GateMDR} + {2'b0, dp.GateALU} + {2'b0, dp.GateMARMUX};
    bus_err_d = bus_err_q | (gate_cnt >= 3'd2);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) bus_err_q <= 1'b0;
    else       bus_err_q <= bus_err_d;
  end

  assign dp.bus_err = bus_err_q;
`else
  assign dp.bus_err = 1'b0;
`endif

  assign dp.PC      = pc_q;
  assign dp.IR      = ir_q;
  assign dp.MAR     = mar_q;
  assign dp.MDR     = mdr_q;
  assign dp.BEN     = ben_q;
  assign dp.LED     = led_q;
  assign dp.dbg_bus = bus;
  assign dp.dbg_cc  = cc_q;

endmodule

// File: tb/tb_lc3_datapath_param.sv
// Directed bench for lc3_datapath_param with hand-computed expectations.
module tb_lc3_datapath_param;

  localparam int W  = 16;
  localparam int LW = 12;
`ifdef DATAPATH_BUS_CHECK_EN
  localparam logic EXP_BUS_ERR = 1'b1;
`else
  localparam logic EXP_BUS_ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];

  lc3_datapath_param_if #(.WIDTH(W), .LED_W(LW)) dp_if ();

  lc3_datapath_param #(.WIDTH(W), .RESET_PC(16'h0000), .LED_W(LW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .dp    (dp_if)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle();
    dp_if.GatePC = 0; dp_if.GateMDR = 0; dp_if.GateALU = 0; dp_if.GateMARMUX = 0;
    dp_if.LD_MAR = 0; dp_if.LD_MDR = 0; dp_if.LD_IR = 0; dp_if.LD_BEN = 0;
    dp_if.LD_CC = 0; dp_if.LD_REG = 0; dp_if.LD_PC = 0; dp_if.LD_LED = 0;
    dp_if.PCMUX = 2'b00; dp_if.DRMUX = 2'b00; dp_if.ADDR2MUX = 2'b00; dp_if.ALUK = 2'b00;
    dp_if.SR1MUX = 0; dp_if.SR2MUX = 0; dp_if.ADDR1MUX = 0; dp_if.MIO_EN = 0;
    dp_if.MDR_In = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr_ext(input logic [W-1:0] v);
    idle();
    dp_if.MDR_In = v; dp_if.MIO_EN = 1; dp_if.LD_MDR = 1;
    tick();
    idle();
  endtask

  task automatic load_ir(input logic [W-1:0] v);
    load_mdr_ext(v);
    dp_if.GateMDR = 1; dp_if.LD_IR = 1;
    tick();
    idle();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", dp_if.PC, 16'h0000);
    check("rst_ir", dp_if.IR, 16'h0000);
    check("rst_mar", dp_if.MAR, 16'h0000);
    check("rst_mdr", dp_if.MDR, 16'h0000);
    check("rst_cc", dp_if.dbg_cc, 3'b010);
    check("rst_ben", dp_if.BEN, 1'b0);
    check("rst_led", dp_if.LED, 12'h000);
    check("rst_bus_err", dp_if.bus_err, 1'b0);
    check("idle_bus", dp_if.dbg_bus, 16'h0000);
    rst = 1'b0;
    tick();

    // PC=0x10 via bus, also into R0 and CC, then async reset mid-cycle
    load_mdr_ext(16'h0010);
    dp_if.GateMDR = 1; dp_if.PCMUX = 2'b01; dp_if.LD_PC = 1; dp_if.LD_CC = 1; dp_if.LD_REG = 1;
    tick();
    idle();
    check("pc_from_bus", dp_if.PC, 16'h0010);
    check("cc_pos_0x10", dp_if.dbg_cc, 3'b001);
    dp_if.GateALU = 1; dp_if.ALUK = 2'b11;
    #1;
    check("r0_written", dp_if.dbg_bus, 16'h0010);
    dp_if.LD_PC = 1; dp_if.PCMUX = 2'b00;
    #1 rst = 1'b1;
    #1;
    check("async_rst_pc", dp_if.PC, 16'h0000);
    check("async_rst_cc", dp_if.dbg_cc, 3'b010);
    check("async_rst_mdr", dp_if.MDR, 16'h0000);
    check("async_rst_r0", dp_if.dbg_bus, 16'h0000);
    #1 rst = 1'b0;
    idle();
    tick();
    check("post_rst_pc", dp_if.PC, 16'h0000);

    // register load through MDR
    load_ir(16'h0200);
    check("ir_load", dp_if.IR, 16'h0200);
    load_mdr_ext(16'h0005);
    check("mdr_ext", dp_if.MDR, 16'h0005);
    dp_if.GateMDR = 1; dp_if.DRMUX = 2'b00; dp_if.LD_REG = 1; dp_if.LD_CC = 1;
    tick();
    idle();
    check("cc_after_r1_5", dp_if.dbg_cc, 3'b001);
    dp_if.GateALU = 1; dp_if.ALUK = 2'b11; dp_if.SR1MUX = 0;
    #1;
    check("r1_eq_5", dp_if.dbg_bus, 16'h0005);
    idle();
    dp_if.LD_LED = 1;
    tick();
    idle();
    check("led_latch", dp_if.LED, 12'h200);

    // ADD R1,R1,#1 then NOT R1
    load_ir(16'h1261);
    dp_if.SR1MUX = 1; dp_if.SR2MUX = 1; dp_if.ALUK = 2'b00;
    dp_if.GateALU = 1; dp_if.LD_REG = 1; dp_if.LD_CC = 1;
    #1;
    check("add_imm_bus", dp_if.dbg_bus, 16'h0006);
    tick();
    check("add_imm_cc", dp_if.dbg_cc, 3'b001);
    dp_if.LD_REG = 0; dp_if.LD_CC = 0; dp_if.ALUK = 2'b11;
    #1;
    check("r1_eq_6", dp_if.dbg_bus, 16'h0006);
    dp_if.ALUK = 2'b10; dp_if.LD_REG = 1; dp_if.LD_CC = 1;
    #1;
    check("not_bus", dp_if.dbg_bus, 16'hFFF9);
    tick();
    check("not_cc", dp_if.dbg_cc, 3'b100);
    idle();
    dp_if.GateALU = 1; dp_if.ALUK = 2'b11; dp_if.SR1MUX = 1;
    #1;
    check("r1_eq_fff9", dp_if.dbg_bus, 16'hFFF9);
    idle();

    // BEN
    load_ir(16'h0400);
    dp_if.LD_CC = 1;
    tick();
    idle();
    check("cc_zero_bus", dp_if.dbg_cc, 3'b010);
    dp_if.LD_BEN = 1;
    tick();
    idle();
    check("ben_z_taken", dp_if.BEN, 1'b1);
    dp_if.GateMDR = 1; dp_if.LD_CC = 1; dp_if.LD_BEN = 1;
    tick();
    idle();
    check("ben_uses_old_cc", dp_if.BEN, 1'b1);
    check("cc_pos_0x400", dp_if.dbg_cc, 3'b001);
    dp_if.LD_BEN = 1;
    tick();
    idle();
    check("ben_p_not_taken", dp_if.BEN, 1'b0);

    // PC increment and address adder
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    for (int i = 0; i < 3; i++) begin
      dp_if.PCMUX = 2'b00; dp_if.LD_PC = 1;
      tick();
      check("pc_inc", dp_if.PC, exp_q.pop_front());
    end
    idle();
    load_ir(16'h01FF);
    dp_if.ADDR1MUX = 0; dp_if.ADDR2MUX = 2'b10; dp_if.PCMUX = 2'b10; dp_if.LD_PC = 1;
    dp_if.GateMARMUX = 1; dp_if.LD_MAR = 1;
    #1;
    check("marmux_bus", dp_if.dbg_bus, 16'h0002);
    tick();
    check("pc_off9", dp_if.PC, 16'h0002);
    check("mar_off9", dp_if.MAR, 16'h0002);
    idle();
    dp_if.ADDR2MUX = 2'b11; dp_if.PCMUX = 2'b10; dp_if.LD_PC = 1;
    tick();
    check("pc_off11", dp_if.PC, 16'h0201);
    dp_if.ADDR2MUX = 2'b01;
    tick();
    check("pc_off6", dp_if.PC, 16'h0200);
    dp_if.PCMUX = 2'b11;
    tick();
    check("pc_hold", dp_if.PC, 16'h0200);
    idle();

    // bus contention and priority
    check("bus_err_before", dp_if.bus_err, 1'b0);
    dp_if.GatePC = 1; dp_if.GateALU = 1; dp_if.ALUK = 2'b10;
    #1;
    check("prio_pc_over_alu", dp_if.dbg_bus, 16'h0200);
    tick();
    idle();
    check("bus_err_set", dp_if.bus_err, EXP_BUS_ERR);
    dp_if.GateMDR = 1; dp_if.GateALU = 1; dp_if.ALUK = 2'b10;
    #1;
    check("prio_mdr_over_alu", dp_if.dbg_bus, 16'h01FF);
    idle();
    dp_if.GateALU = 1; dp_if.GateMARMUX = 1; dp_if.ALUK = 2'b11;
    #1;
    check("prio_alu_over_mar", dp_if.dbg_bus, 16'h0000);
    idle();
    tick();
    tick();
    check("bus_err_sticky", dp_if.bus_err, EXP_BUS_ERR);
    rst = 1'b1;
    #1;
    check("bus_err_rst", dp_if.bus_err, 1'b0);
    check("pc_final_rst", dp_if.PC, 16'h0000);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
